keypad_timer_entry: RTL and testbench

//   Parametrised keypad/timebase front end for the microwave timer; single clock domain.

---
 rtl/keypad_timer_entry_if.sv | 16 +
 rtl/keypad_timer_entry.sv | 137 +++++++++++++
 tb/tb_keypad_timer_entry.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_timer_entry_if.sv
// Keypad front-end bus: raw key/mode inputs toward the block, entry/tick outputs back.
interface keypad_timer_entry_if #(parameter int NDIGITS = 4);
   logic [0:9]           keypad;
   logic                 enablen;
   logic                 clear_entry;
   logic [4*NDIGITS-1:0] digits;
   logic [3:0]           bcd;
   logic                 key_valid;
   logic                 loadn;
   logic                 tick;

   modport master (output keypad, enablen, clear_entry,
                   input  digits, bcd, key_valid, loadn, tick);
   modport slave  (input  keypad, enablen, clear_entry,
                   output digits, bcd, key_valid, loadn, tick);
endinterface

// File: rtl/keypad_timer_entry.sv
// Keypad encoder + debounce FSM + BCD entry shift register + countdown tick generator.
module keypad_timer_entry #(
   parameter int NDIGITS  = 4,
   parameter int CLK_DIV  = 100,
   parameter int DEBOUNCE = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   keypad_timer_entry_if.slave  bus
);
   localparam int DIV_W = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
   localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

   state_t               state, nxt;
   logic [DB_W-1:0]      cnt, cnt_nxt;
   logic [3:0]           code, latched, latched_nxt;
   logic                 raw, accept, loadn_nxt;
   logic [DIV_W-1:0]     cnt_div;
   logic [4*NDIGITS-1:0] digits_q, shifted;
   logic [3:0]           bcd_q;
   logic                 key_valid_q, loadn_q;

   // Scan from the top so the lowest asserted key overwrites and wins.
   always_comb begin
      code = '0;
      for (int i = 9; i >= 0; i--)
         if (bus.keypad[i]) code = 4'(i);
      raw = |bus.keypad;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         latched <= '0;
      end else begin
         state   <= nxt;
         cnt     <= cnt_nxt;
         latched <= latched_nxt;
      end
   end

   always_comb begin
      nxt         = state;
      cnt_nxt     = cnt;
      latched_nxt = latched;
      accept      = 1'b0;
      if (bus.enablen) begin
         nxt     = IDLE;
         cnt_nxt = '0;
      end else begin
         case (state)
            IDLE:
               if (raw) begin
                  nxt         = PRESS_WAIT;
                  latched_nxt = code;
                  cnt_nxt     = '0;
               end
            PRESS_WAIT:
               if (!raw || code != latched) begin
                  nxt     = IDLE;
                  cnt_nxt = '0;
               end else if (cnt == DB_LAST) begin
                  nxt     = HELD;
                  cnt_nxt = '0;
                  accept  = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            // Code changes while held are deliberately ignored: one accept per press.
            HELD:
               if (!raw) begin
                  nxt     = RELEASE_WAIT;
                  cnt_nxt = '0;
               end
            RELEASE_WAIT:
               if (raw) begin
                  nxt     = HELD;
                  cnt_nxt = '0;
               end else if (cnt == DB_LAST) begin
                  nxt     = IDLE;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            default: begin
               nxt     = IDLE;
               cnt_nxt = '0;
            end
         endcase
      end
   end

   always_comb begin
      loadn_nxt = !(nxt == HELD || nxt == RELEASE_WAIT);
   end

   generate
      if (NDIGITS == 1) begin : g_one
         assign shifted = latched;
      end else begin : g_multi
         assign shifted = {digits_q[4*NDIGITS-5:0], latched};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         digits_q    <= '0;
         bcd_q       <= '0;
         key_valid_q <= 1'b0;
         loadn_q     <= 1'b1;
      end else begin
         key_valid_q <= accept;
         loadn_q     <= loadn_nxt;
         if (accept) bcd_q <= latched;
         if (bus.clear_entry)  digits_q <= '0;
         else if (accept)      digits_q <= shifted;
      end
   end

   // Divider parks at zero while idle so each cooking run starts a full period.
   always_ff @(posedge clk) begin
      if (reset || !bus.enablen)  cnt_div <= '0;
      else if (cnt_div == DIV_LAST) cnt_div <= '0;
      else                          cnt_div <= cnt_div + 1'b1;
   end

   assign bus.tick      = bus.enablen ? (cnt_div == DIV_LAST) : key_valid_q;
   assign bus.digits    = digits_q;
   assign bus.bcd       = bcd_q;
   assign bus.key_valid = key_valid_q;
   assign bus.loadn     = loadn_q;
endmodule

// File: tb/tb_keypad_timer_entry.sv
// Directed bench for keypad_timer_entry: press table plus bounce, timebase and reset sequences.
module tb_keypad_timer_entry;
   logic clk = 1'b0;
   logic reset;

   keypad_timer_entry_if #(.NDIGITS(4)) bus ();

   keypad_timer_entry #(.NDIGITS(4), .CLK_DIV(100), .DEBOUNCE(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  keys;        // bit i = key i
      int          hold;        // edges the keys stay asserted (>=4)
      bit          clr;         // assert clear_entry in the accept cycle
      logic [3:0]  exp_bcd;
      logic [15:0] exp_digits;
   } vec_t;

   vec_t vecs[9];
   int   n_run  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_keys(input logic [9:0] k);
      for (int i = 0; i < 10; i++) bus.keypad[i] = k[i];
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_digits"},    32'(bus.digits),    32'h0);
      check({tag, "_bcd"},       32'(bus.bcd),       32'h0);
      check({tag, "_key_valid"}, 32'(bus.key_valid), 32'h0);
      check({tag, "_loadn"},     32'(bus.loadn),     32'h1);
      check({tag, "_tick"},      32'(bus.tick),      32'h0);
   endtask

   task automatic release_keys(input string tag);
      set_keys(10'h0);
      for (int j = 0; j < 4; j++) begin
         step();
         check({tag, "_rel_loadn"}, 32'(bus.loadn), (j == 3) ? 32'h1 : 32'h0);
         check({tag, "_rel_kv"},    32'(bus.key_valid), 32'h0);
      end
   endtask

   task automatic press(input vec_t v, input int idx);
      int    pulses;
      string tag;
      pulses = 0;
      tag = $sformatf("press%0d", idx);
      set_keys(v.keys);
      for (int j = 0; j < v.hold; j++) begin
         if (j == 3 && v.clr) bus.clear_entry = 1'b1;
         step();
         bus.clear_entry = 1'b0;
         if (bus.key_valid) pulses++;
         check({tag, "_kv"},    32'(bus.key_valid), (j == 3) ? 32'h1 : 32'h0);
         check({tag, "_tick"},  32'(bus.tick),      (j == 3) ? 32'h1 : 32'h0);
         check({tag, "_loadn"}, 32'(bus.loadn),     (j >= 3) ? 32'h0 : 32'h1);
      end
      check({tag, "_bcd"},    32'(bus.bcd),    32'(v.exp_bcd));
      check({tag, "_digits"}, 32'(bus.digits), 32'(v.exp_digits));
      release_keys(tag);
      check({tag, "_pulses"}, 32'(pulses), 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses;
      vecs[0] = '{10'h080, 10, 1'b0, 4'd7, 16'h0007};
      vecs[1] = '{10'h002,  5, 1'b0, 4'd1, 16'h0071};
      vecs[2] = '{10'h004,  5, 1'b0, 4'd2, 16'h0712};
      vecs[3] = '{10'h008,  5, 1'b0, 4'd3, 16'h7123};
      vecs[4] = '{10'h010,  5, 1'b0, 4'd4, 16'h1234};
      vecs[5] = '{10'h020,  5, 1'b0, 4'd5, 16'h2345};
      vecs[6] = '{10'h208,  5, 1'b1, 4'd3, 16'h0000};  // keys 3 and 9, cleared on accept
      vecs[7] = '{10'h100,  4, 1'b0, 4'd8, 16'h0008};
      vecs[8] = '{10'h3FF,  4, 1'b0, 4'd0, 16'h0080};  // all keys: key 0 wins

      reset = 1'b1;
      set_keys(10'h0);
      bus.enablen     = 1'b0;
      bus.clear_entry = 1'b0;
      step();
      step();
      check_reset_vals("reset");
      reset = 1'b0;
      step();

      for (int v = 0; v < 9; v++) press(vecs[v], v);

      // Bounce on key 4, then stable; key change while held must not re-accept.
      for (int b = 0; b < 3; b++) begin
         set_keys(10'h010);
         for (int j = 0; j < 2; j++) begin
            step();
            check("bounce_kv",    32'(bus.key_valid), 32'h0);
            check("bounce_loadn", 32'(bus.loadn),     32'h1);
         end
         set_keys(10'h0);
         step();
         step();
      end
      pulses = 0;
      set_keys(10'h010);
      for (int j = 0; j < 12; j++) begin
         step();
         if (bus.key_valid) pulses++;
         check("stable_kv", 32'(bus.key_valid), (j == 3) ? 32'h1 : 32'h0);
      end
      set_keys(10'h004);
      for (int j = 0; j < 6; j++) begin
         step();
         if (bus.key_valid) pulses++;
         check("held_change_loadn", 32'(bus.loadn), 32'h0);
      end
      release_keys("bounce");
      check("bounce_pulses", 32'(pulses), 32'h1);
      check("bounce_bcd",    32'(bus.bcd),    32'h4);
      check("bounce_digits", 32'(bus.digits), 32'h0804);

      // enablen rising while HELD forces an immediate release.
      set_keys(10'h002);
      for (int j = 0; j < 5; j++) begin
         step();
         check("lock_press_kv", 32'(bus.key_valid), (j == 3) ? 32'h1 : 32'h0);
      end
      check("lock_press_digits", 32'(bus.digits), 32'h8041);
      set_keys(10'h0);
      bus.enablen = 1'b1;
      step();
      check("lock_loadn", 32'(bus.loadn),     32'h1);
      check("lock_kv",    32'(bus.key_valid), 32'h0);
      check("lock_tick",  32'(bus.tick),      32'h0);
      bus.enablen = 1'b0;
      for (int j = 0; j < 3; j++) step();

      // Timebase: 350 cycles cooking with a key pressed in the middle.
      bus.enablen = 1'b1;
      for (int n = 0; n < 350; n++) begin
         check("tb_tick",  32'(bus.tick),      (n % 100 == 99) ? 32'h1 : 32'h0);
         check("tb_kv",    32'(bus.key_valid), 32'h0);
         check("tb_loadn", 32'(bus.loadn),     32'h1);
         if (n == 20)  set_keys(10'h040);
         if (n == 300) set_keys(10'h0);
         step();
      end
      bus.enablen = 1'b0;
      for (int n = 0; n < 150; n++) begin
         check("idle_tick", 32'(bus.tick), 32'h0);
         step();
      end
      check("tb_digits", 32'(bus.digits), 32'h8041);
      check("tb_bcd",    32'(bus.bcd),    32'h1);

      // Reset while HELD: everything back to reset values, no accept on release.
      set_keys(10'h200);
      for (int j = 0; j < 5; j++) step();
      check("pre_reset_loadn", 32'(bus.loadn), 32'h0);
      reset = 1'b1;
      step();
      check_reset_vals("held_reset");
      reset = 1'b0;
      set_keys(10'h0);
      for (int j = 0; j < 8; j++) begin
         step();
         check("post_reset_kv",    32'(bus.key_valid), 32'h0);
         check("post_reset_loadn", 32'(bus.loadn),     32'h1);
      end
      check("post_reset_digits", 32'(bus.digits), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
